operand_stage: RTL and testbench
================================

# operand_stage

Decode/operand-fetch stage of the 3-stage pipeline (fetch → operand_stage → execute/writeback), sitting directly upstream of the ALU. It decodes each 16-bit instruction and reads a 16×16 register file, with r0 hard-wired to zero. It forms the ALU's operand1, operand2, carry_in and opcode, and holds them in a valid/ready pipeline register. It also owns the architectural carry flag and applies same-cycle writeback bypassing, so the execute stage never sees stale operands.

## Interface
- DATA_W, 16, datapath width
- REG_AW, 4, register address width (2^REG_AW registers)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2 or imm4
- flush  in  1  discard the held instruction and the one being accepted
- out_valid  out  1  operand register holds a valid instruction
- out_ready  in  1  execute stage consumes outputs this cycle
- out_opcode  out  4  to ALU opcode
- out_operand1  out  DATA_W  to ALU operand1
- out_operand2  out  DATA_W  to ALU operand2
- out_carry_in  out  1  to ALU carry_in
- out_rd  out  REG_AW  destination register for writeback
- wb_en  in  1  writeback of wb_data to wb_rd
- wb_rd  in  REG_AW  writeback destination
- wb_data  in  DATA_W  writeback value (ALU result)
- wb_carry_en  in  1  update carry flag (asserted by execute for ADDC/SUBC)
- wb_carry  in  1  new carry flag (ALU carry_out)

## Operation
- Immediate ops (ANDI, ORI, XORI): operand2 = imm4 zero-extended. ADDI and SUBI: operand2 = imm4 sign-extended.
- All other opcodes, including unknown ones: operand2 = R[rs2]. operand1 = R[rs1] always.
- carry_in = carry flag for ADDC/SUBC; 0 for all other opcodes.
- Reads of r0 return 0. Writes to r0 are ignored.
- Bypass: if wb_en and wb_rd == rs (rs ≠ 0), the read returns wb_data instead of the array value. Likewise, if wb_carry_en, carry_in takes wb_carry.
- Writeback and carry updates commit at the clock edge unconditionally, independent of stall or flush.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Load occurs when in_valid && in_ready && !flush.
  - If in_ready is high and no load occurs, out_valid clears.
- Hold refresh: while out_valid && !out_ready, a writeback matching the held rs1, or the held rs2 of a non-immediate op, replaces that held operand. A carry update does the same for the held carry_in of ADDC/SUBC. To support this, held rs1/rs2/immediate-flag are kept internally.
- flush: out_valid clears next edge. Flush has priority over load. The other out_* fields keep their values.
- Unknown opcodes pass through unchanged. The ALU defines their result.

## Timing
- Reset (async assert, sync release): out_valid = 0, all out_* = 0, all registers = 0, carry flag = 0.
- Latency: instruction accepted at edge N appears on out_* after edge N, with out_valid = 1.
- Throughput: one instruction per cycle when out_ready is held high.
- Out-of-range/wrap: imm4 = 4'hF gives operand2 = 16'hFFFF for ADDI/SUBI and 16'h000F for ANDI/ORI/XORI.
- Simultaneous events:
  - Writeback to rs at the same edge as load: the loaded operand is wb_data.
  - Writeback to r0: operand stays 0.
  - flush with out_ready low: out_valid still clears.
- Reset mid-stall: the held instruction is lost and out_valid = 0 immediately.

## Structure
- Shared include opcodes.vh holds the opcode macros. Add instruction field macros there: OPC_MSB/LSB, RD, RS1, RS2/IMM positions.
- Sub-module regfile_2r1w holds the 16×DATA_W array: 2 async read ports, 1 sync write port, async active-low reset, r0 forced zero. Bypass muxing stays in operand_stage.
- Carry flag, operand register, hold-refresh and handshake logic stay in operand_stage.

## Test plan
- Reset then ADDI r1,r0,#-1: out_operand1 = 0, out_operand2 = 16'hFFFF, out_rd = 1, out_carry_in = 0, out_valid after 1 edge.
- Same-cycle bypass: wb_en, wb_rd = 2, wb_data = 16'h1234 on the edge loading AND r3,r2,r2 → both operands = 16'h1234. A write to r0 with 16'hBEEF, then reading r0 → 0.
- Carry: wb_carry_en, wb_carry = 1, then ADDC r4,r1,r2 → out_carry_in = 1. XOR r4,r1,r2 → out_carry_in = 0.
- Stall with refresh: out_ready low holding SUB-free ADD-class op reading r5; wb writes r5 = 16'h00AA → held out_operand1 becomes 16'h00AA, in_ready = 0. out_ready rises → next instruction accepted the same cycle.
- flush while in_valid and in_ready → out_valid = 0 next edge, no load. flush during a stall → out_valid = 0.
- Back-to-back stream of 8 instructions with out_ready held high → 8 consecutive out_valid cycles with correct operands. rst_n pulled low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// Shared opcode encodings, instruction field positions and decode helpers
// for the operand_stage pipeline slice.
package operand_stage_pkg;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_ADDC = 4'h5,
    OP_SUBC = 4'h6,
    OP_ADDI = 4'h7,
    OP_SUBI = 4'h8,
    OP_ANDI = 4'h9,
    OP_ORI  = 4'hA,
    OP_XORI = 4'hB
  } opcode_e;

  function automatic logic is_imm_op(input logic [3:0] opc);
    return (opc == OP_ADDI) || (opc == OP_SUBI) || (opc == OP_ANDI) ||
           (opc == OP_ORI)  || (opc == OP_XORI);
  endfunction

  function automatic logic is_sext_op(input logic [3:0] opc);
    return (opc == OP_ADDI) || (opc == OP_SUBI);
  endfunction

  function automatic logic uses_carry_op(input logic [3:0] opc);
    return (opc == OP_ADDC) || (opc == OP_SUBC);
  endfunction

endpackage

// File: rtl/operand_stage_regfile_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write
// port; r0 reads as zero and ignores writes.
module regfile_2r1w #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/operand_stage.sv
// Decode/operand-fetch stage: register read with writeback bypass, carry
// flag ownership, and a valid/ready operand register with hold refresh.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [DATA_W-1:0] out_operand1,
  output logic [DATA_W-1:0] out_operand2,
  output logic              out_carry_in,
  output logic [REG_AW-1:0] out_rd,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_carry_en,
  input  logic              wb_carry
);

  logic [3:0]        opc;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [3:0]        imm;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, src1, src2, imm_ext, op2;
  logic              imm_op, cin, carry_now, load;

  logic              valid_q, valid_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic              cin_q, cin_d;
  logic [REG_AW-1:0] rd_q, rd_d, hrs1_q, hrs1_d, hrs2_q, hrs2_d;
  logic              himm_q, himm_d;
  logic              carry_q;

  assign opc = in_instr[OPC_MSB:OPC_LSB];
  assign rd  = in_instr[RD_MSB:RD_LSB];
  assign rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign rs2 = in_instr[RS2_MSB:RS2_LSB];
  assign imm = in_instr[IMM_MSB:IMM_LSB];

  regfile_2r1w #(.DATA_W(DATA_W), .AW(REG_AW)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .rd1   (rf_rd1),
    .ra2   (rs2),
    .rd2   (rf_rd2),
    .we    (wb_en),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // The regfile already zeroes r0, so the bypass only needs the rs != 0 guard.
  assign src1      = (wb_en && (wb_rd == rs1) && (rs1 != '0)) ? wb_data : rf_rd1;
  assign src2      = (wb_en && (wb_rd == rs2) && (rs2 != '0)) ? wb_data : rf_rd2;
  assign imm_op    = is_imm_op(opc);
  assign imm_ext   = is_sext_op(opc) ? {{(DATA_W-4){imm[3]}}, imm}
                                     : {{(DATA_W-4){1'b0}}, imm};
  assign op2       = imm_op ? imm_ext : src2;
  assign carry_now = wb_carry_en ? wb_carry : carry_q;
  assign cin       = uses_carry_op(opc) ? carry_now : 1'b0;

  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready && !flush;

  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    cin_d    = cin_q;
    rd_d     = rd_q;
    hrs1_d   = hrs1_q;
    hrs2_d   = hrs2_q;
    himm_d   = himm_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      opcode_d = opc;
      op1_d    = src1;
      op2_d    = op2;
      cin_d    = cin;
      rd_d     = rd;
      hrs1_d   = rs1;
      hrs2_d   = rs2;
      himm_d   = imm_op;
    end else if (in_ready) begin
      valid_d = 1'b0;
    end else begin
      // Stalled: keep the held operands coherent with commits happening now.
      if (wb_en && (wb_rd != '0) && (wb_rd == hrs1_q)) op1_d = wb_data;
      if (wb_en && (wb_rd != '0) && (wb_rd == hrs2_q) && !himm_q) op2_d = wb_data;
      if (wb_carry_en && uses_carry_op(opcode_q)) cin_d = wb_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      cin_q    <= 1'b0;
      rd_q     <= '0;
      hrs1_q   <= '0;
      hrs2_q   <= '0;
      himm_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      cin_q    <= cin_d;
      rd_q     <= rd_d;
      hrs1_q   <= hrs1_d;
      hrs2_q   <= hrs2_d;
      himm_q   <= himm_d;
      if (wb_carry_en) carry_q <= wb_carry;
    end
  end

  assign out_valid    = valid_q;
  assign out_opcode   = opcode_q;
  assign out_operand1 = op1_q;
  assign out_operand2 = op2_q;
  assign out_carry_in = cin_q;
  assign out_rd       = rd_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage; the bench acts as fetch and execute,
// driving writebacks itself and checking against hand-computed vectors.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_instr;
  logic [3:0]  out_opcode, out_rd, wb_rd;
  logic [15:0] out_operand1, out_operand2, wb_data;
  logic        out_carry_in, wb_en, wb_carry_en, wb_carry;

  int total = 0;
  int bad   = 0;

  // {valid, opcode, rd, carry_in, operand1, operand2}
  logic [41:0] obs;
  assign obs = {out_valid, out_opcode, out_rd, out_carry_in, out_operand1, out_operand2};

  always #5 clk = ~clk;

  operand_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_operand1 (out_operand1),
    .out_operand2 (out_operand2),
    .out_carry_in (out_carry_in),
    .out_rd       (out_rd),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_carry_en  (wb_carry_en),
    .wb_carry     (wb_carry)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; wb_carry_en = 1'b0; wb_carry = 1'b0;
    #1;
    total++; if (obs !== 42'h0) begin bad++; $display("FAIL reset_outs got=%h exp=%h", obs, 42'h0); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    #12 rst_n = 1'b1;
  endtask

  task automatic test_imm();
    in_valid = 1'b1; in_instr = 16'h710F;   // ADDI r1,r0,#-1
    cyc();
    total++; if (obs !== {1'b1, 4'h7, 4'h1, 1'b0, 16'h0000, 16'hFFFF}) begin bad++; $display("FAIL addi_sext got=%h", obs); end
    in_instr = 16'h910F;                    // ANDI r1,r0,#F
    cyc();
    total++; if (obs !== {1'b1, 4'h9, 4'h1, 1'b0, 16'h0000, 16'h000F}) begin bad++; $display("FAIL andi_zext got=%h", obs); end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_rd = 4'd2; wb_data = 16'h1234; in_instr = 16'h2322;  // AND r3,r2,r2
    cyc();
    total++; if (obs !== {1'b1, 4'h2, 4'h3, 1'b0, 16'h1234, 16'h1234}) begin bad++; $display("FAIL bypass_same_edge got=%h", obs); end
    wb_en = 1'b0;
    cyc();
    total++; if (obs !== {1'b1, 4'h2, 4'h3, 1'b0, 16'h1234, 16'h1234}) begin bad++; $display("FAIL rf_read_back got=%h", obs); end
    wb_en = 1'b1; wb_rd = 4'd0; wb_data = 16'hBEEF; in_instr = 16'h0500;  // ADD r5,r0,r0
    cyc();
    total++; if (obs !== {1'b1, 4'h0, 4'h5, 1'b0, 16'h0000, 16'h0000}) begin bad++; $display("FAIL r0_no_bypass got=%h", obs); end
    wb_en = 1'b0;
    cyc();
    total++; if (obs !== {1'b1, 4'h0, 4'h5, 1'b0, 16'h0000, 16'h0000}) begin bad++; $display("FAIL r0_no_write got=%h", obs); end
  endtask

  task automatic test_carry();
    wb_carry_en = 1'b1; wb_carry = 1'b1; in_instr = 16'h5412;  // ADDC r4,r1,r2
    cyc();
    total++; if (obs !== {1'b1, 4'h5, 4'h4, 1'b1, 16'h0000, 16'h1234}) begin bad++; $display("FAIL carry_bypass got=%h", obs); end
    wb_carry_en = 1'b0;
    cyc();
    total++; if (obs !== {1'b1, 4'h5, 4'h4, 1'b1, 16'h0000, 16'h1234}) begin bad++; $display("FAIL carry_flag got=%h", obs); end
    in_instr = 16'h4412;                                       // XOR r4,r1,r2
    cyc();
    total++; if (obs !== {1'b1, 4'h4, 4'h4, 1'b0, 16'h0000, 16'h1234}) begin bad++; $display("FAIL carry_nonc got=%h", obs); end
    wb_carry_en = 1'b1; wb_carry = 1'b0; in_instr = 16'h6412; // SUBC r4,r1,r2
    cyc();
    total++; if (obs !== {1'b1, 4'h6, 4'h4, 1'b0, 16'h0000, 16'h1234}) begin bad++; $display("FAIL carry_clear got=%h", obs); end
    wb_carry_en = 1'b0;
  endtask

  task automatic test_stall();
    in_instr = 16'h0651;                                      // ADD r6,r5,r1
    cyc();
    total++; if (obs !== {1'b1, 4'h0, 4'h6, 1'b0, 16'h0000, 16'h0000}) begin bad++; $display("FAIL stall_load got=%h", obs); end
    out_ready = 1'b0; in_instr = 16'h3722;                    // OR r7,r2,r2 waits
    wb_en = 1'b1; wb_rd = 4'd5; wb_data = 16'h00AA;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    cyc();
    total++; if (obs !== {1'b1, 4'h0, 4'h6, 1'b0, 16'h00AA, 16'h0000}) begin bad++; $display("FAIL refresh_rs1 got=%h", obs); end
    wb_rd = 4'd1; wb_data = 16'h0055;
    cyc();
    total++; if (obs !== {1'b1, 4'h0, 4'h6, 1'b0, 16'h00AA, 16'h0055}) begin bad++; $display("FAIL refresh_rs2 got=%h", obs); end
    wb_en = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    cyc();
    total++; if (obs !== {1'b1, 4'h3, 4'h7, 1'b0, 16'h1234, 16'h1234}) begin bad++; $display("FAIL release_accept got=%h", obs); end
    in_instr = 16'h7123;                                      // ADDI r1,r2,#3
    cyc();
    out_ready = 1'b0; wb_en = 1'b1; wb_rd = 4'd3; wb_data = 16'h7777;
    cyc();
    total++; if (obs !== {1'b1, 4'h7, 4'h1, 1'b0, 16'h1234, 16'h0003}) begin bad++; $display("FAIL imm_not_refreshed got=%h", obs); end
    out_ready = 1'b1; wb_en = 1'b0; in_instr = 16'h5412;      // ADDC r4,r1,r2
    cyc();
    out_ready = 1'b0; wb_carry_en = 1'b1; wb_carry = 1'b1;
    cyc();
    total++; if (obs !== {1'b1, 4'h5, 4'h4, 1'b1, 16'h0055, 16'h1234}) begin bad++; $display("FAIL refresh_carry got=%h", obs); end
    wb_carry_en = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_flush();
    in_instr = 16'h4921;                                      // XOR r9,r2,r1
    cyc();
    flush = 1'b1; in_instr = 16'h0A12;
    cyc();
    total++; if (obs !== {1'b0, 4'h4, 4'h9, 1'b0, 16'h1234, 16'h0055}) begin bad++; $display("FAIL flush_no_load got=%h", obs); end
    flush = 1'b0; in_instr = 16'h4921;
    cyc();
    out_ready = 1'b0; flush = 1'b1;
    cyc();
    total++; if (obs !== {1'b0, 4'h4, 4'h9, 1'b0, 16'h1234, 16'h0055}) begin bad++; $display("FAIL flush_in_stall got=%h", obs); end
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] instrs [8];
    logic [41:0] exps   [8];
    // r1=0055 r2=1234 r3=7777 r5=00AA, all other registers zero
    instrs[0] = 16'h7125; exps[0] = {1'b1, 4'h7, 4'h1, 1'b0, 16'h1234, 16'h0005};
    instrs[1] = 16'h8238; exps[1] = {1'b1, 4'h8, 4'h2, 1'b0, 16'h7777, 16'hFFF8};
    instrs[2] = 16'hA35F; exps[2] = {1'b1, 4'hA, 4'h3, 1'b0, 16'h00AA, 16'h000F};
    instrs[3] = 16'h0412; exps[3] = {1'b1, 4'h0, 4'h4, 1'b0, 16'h0055, 16'h1234};
    instrs[4] = 16'h1535; exps[4] = {1'b1, 4'h1, 4'h5, 1'b0, 16'h7777, 16'h00AA};
    instrs[5] = 16'hF623; exps[5] = {1'b1, 4'hF, 4'h6, 1'b0, 16'h1234, 16'h7777};
    instrs[6] = 16'hB71C; exps[6] = {1'b1, 4'hB, 4'h7, 1'b0, 16'h0055, 16'h000C};
    instrs[7] = 16'h2805; exps[7] = {1'b1, 4'h2, 4'h8, 1'b0, 16'h0000, 16'h00AA};
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_instr = instrs[i];
      cyc();
      total++; if (obs !== exps[i]) begin bad++; $display("FAIL stream[%0d] got=%h exp=%h", i, obs, exps[i]); end
    end
    in_valid = 1'b0;
    cyc();
    total++; if (obs !== {1'b0, 4'h2, 4'h8, 1'b0, 16'h0000, 16'h00AA}) begin bad++; $display("FAIL stream_drain got=%h", obs); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_instr = 16'h7125;
    cyc();
    rst_n = 1'b0;
    #1;
    total++; if (obs !== 42'h0) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs, 42'h0); end
    #2 rst_n = 1'b1;
    in_instr = 16'h5423;                                      // ADDC r4,r2,r3 after reset
    cyc();
    total++; if (obs !== {1'b1, 4'h5, 4'h4, 1'b0, 16'h0000, 16'h0000}) begin bad++; $display("FAIL regs_after_reset got=%h", obs); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_imm();
    test_bypass();
    test_carry();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
